// File: rtl/circle_pkg.sv
// Shared types and the loop transition table for the running-circle position generator.
package circle_pkg;

  localparam logic COL_UPPER = 1'b0;
  localparam logic COL_LOWER = 1'b1;

  typedef struct packed {
    logic [2:0] row;
    logic       col;
  } pos_t;

  localparam pos_t POS_HOME = '{row: 3'd0, col: COL_UPPER};

  // Forward walks upper 0..n-1, then lower n-1..0; reverse is the exact inverse.
  function automatic pos_t next_pos(pos_t p, logic dir, int unsigned n);
    pos_t       r;
    logic [2:0] last;
    last = 3'(n - 1);
    r    = p;
    if (!dir) begin
      if (p.col == COL_UPPER) begin
        if (p.row == last) r.col = COL_LOWER;
        else               r.row = p.row + 3'd1;
      end else begin
        if (p.row == 3'd0) r.col = COL_UPPER;
        else               r.row = p.row - 3'd1;
      end
    end else begin
      if (p.col == COL_UPPER) begin
        if (p.row == 3'd0) r.col = COL_LOWER;
        else               r.row = p.row - 3'd1;
      end else begin
        if (p.row == last) r.col = COL_UPPER;
        else               r.row = p.row + 3'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Programmable step-rate divider: one-cycle tick every (DIV >> speed_sel_i) enabled cycles.
module step_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned STEP_HZ     = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [1:0] speed_sel_i,
  output logic       tick_o
);

  localparam int unsigned Div  = (CLK_FREQ_HZ / STEP_HZ < 1) ? 1 : CLK_FREQ_HZ / STEP_HZ;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] count_q, count_d, limit_m1;
  logic [31:0]     limit;

  always_comb begin
    limit = 32'(Div) >> speed_sel_i;
    if (limit == 32'd0) limit = 32'd1;
    limit_m1 = CntW'(limit - 32'd1);
    // >= rather than == so a speed-up past the current count fires at once instead of wrapping
    tick_o  = enable_i && (count_q >= limit_m1);
    count_d = (!enable_i || tick_o) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/circle_path_ctrl.sv
// Position generator for the running-circle display: walks the 2*NUM_DIGITS loop on each advance.
module circle_path_ctrl
  import circle_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned STEP_HZ     = 4,
  parameter int unsigned NUM_DIGITS  = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       dir_i,
  input  logic [1:0] speed_sel_i,
  input  logic       step_i,
  output logic [2:0] row_index_o,
  output logic       column_index_o,
  output logic       step_o,
  output logic       lap_o
);

  logic tick;
  logic advance;
  pos_t pos_q, pos_nxt;
  logic step_q, lap_q;

  step_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .STEP_HZ    (STEP_HZ)
  ) u_tick (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .speed_sel_i(speed_sel_i),
    .tick_o     (tick)
  );

  // Manual steps only count while paused.
  assign advance = enable_i ? tick : step_i;
  assign pos_nxt = next_pos(pos_q, dir_i, NUM_DIGITS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q  <= POS_HOME;
      step_q <= 1'b0;
      lap_q  <= 1'b0;
    end else begin
      step_q <= advance;
      lap_q  <= advance && (pos_nxt == POS_HOME);
      if (advance) pos_q <= pos_nxt;
    end
  end

  assign row_index_o    = pos_q.row;
  assign column_index_o = pos_q.col;
  assign step_o         = step_q;
  assign lap_o          = lap_q;

endmodule

// File: tb/tb_circle_path_ctrl.sv
// Bench for circle_path_ctrl: loop-index reference model plus directed scenarios.
module tb_circle_path_ctrl;

  localparam int N = 6;
  localparam int L = 2 * N;

  logic       clk = 1'b0;
  logic       rst, en, dir, step_in;
  logic [1:0] spd;
  logic [2:0] row;
  logic       col, step_o, lap_o;

  int errors = 0;
  int checks = 0;

  // Model: position as an index around the loop, upper r = r, lower r = L-1-r.
  int   m_idx, m_cnt;
  logic m_step, m_lap;

  always #5 clk = ~clk;

  circle_path_ctrl #(
    .CLK_FREQ_HZ(16),
    .STEP_HZ    (2),
    .NUM_DIGITS (N)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (en),
    .dir_i         (dir),
    .speed_sel_i   (spd),
    .step_i        (step_in),
    .row_index_o   (row),
    .column_index_o(col),
    .step_o        (step_o),
    .lap_o         (lap_o)
  );

  logic [5:0] got;
  assign got = {row, col, step_o, lap_o};

  function automatic logic [2:0] exp_row(int idx);
    return (idx < N) ? 3'(idx) : 3'(L - 1 - idx);
  endfunction

  function automatic logic exp_col(int idx);
    return idx >= N;
  endfunction

  function automatic logic [5:0] mdl();
    return {exp_row(m_idx), exp_col(m_idx), m_step, m_lap};
  endfunction

  function automatic logic [3:0] pos_of(int idx);
    return {exp_row(idx), exp_col(idx)};
  endfunction

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_step = 1'b0; m_lap = 1'b0;
  endtask

  // Evaluate the model on the inputs present at the coming edge, then clock.
  task automatic clk_step();
    int lim, nidx;
    bit tk, adv;
    lim  = 8 >> spd;
    if (lim < 1) lim = 1;
    tk   = en && (m_cnt >= lim - 1);
    adv  = en ? tk : step_in;
    nidx = dir ? (m_idx + L - 1) % L : (m_idx + 1) % L;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      m_cnt  = (!en || tk) ? 0 : m_cnt + 1;
      m_step = adv;
      m_lap  = adv && (nidx == 0);
      if (adv) m_idx = nidx;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; step_in = 1'b0; dir = 1'b0; spd = 2'd0;
    clk_step();
    rst = 1'b0;
  endtask

  task automatic pulse_step();
    step_in = 1'b1;
    clk_step();
    step_in = 1'b0;
    clk_step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; step_in = 1'b0; dir = 1'b0; spd = 2'd0;
    model_reset();
    #2;
    checks++;
    if (got !== 6'b0) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", got, 6'b0);
    end
    clk_step(); clk_step();
    checks++;
    if (got !== 6'b0) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", got, 6'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_forward();
    int nsteps = 0, last = 0, lap_at = 0;
    do_reset();
    en = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      clk_step();
      checks++;
      if (got !== mdl()) begin
        errors++; $display("FAIL fwd_model c=%0d got=%b exp=%b", c, got, mdl());
      end
      if (step_o) begin
        nsteps++;
        checks++;
        if (c - last != 8 || got[5:2] !== pos_of(nsteps % L)) begin
          errors++;
          $display("FAIL fwd_step k=%0d gap=%0d pos=%b exp_gap=8 exp_pos=%b",
                   nsteps, c - last, got[5:2], pos_of(nsteps % L));
        end
        last = c;
        if (lap_o) lap_at = nsteps;
      end
    end
    checks++;
    if (nsteps != 12 || lap_at != 12) begin
      errors++; $display("FAIL fwd_count steps=%0d lap_at=%0d exp 12/12", nsteps, lap_at);
    end
  endtask

  task automatic test_reverse();
    int nsteps = 0, laps = 0, lap_at = 0;
    do_reset();
    en = 1'b1; dir = 1'b1;
    for (int c = 1; c <= 96; c++) begin
      clk_step();
      checks++;
      if (got !== mdl()) begin
        errors++; $display("FAIL rev_model c=%0d got=%b exp=%b", c, got, mdl());
      end
      if (step_o) begin
        nsteps++;
        checks++;
        if (got[5:2] !== pos_of((L - nsteps % L) % L)) begin
          errors++;
          $display("FAIL rev_pos k=%0d got=%b exp=%b", nsteps, got[5:2],
                   pos_of((L - nsteps % L) % L));
        end
        if (lap_o) begin laps++; lap_at = nsteps; end
      end
    end
    checks++;
    if (nsteps != 12 || laps != 1 || lap_at != 12) begin
      errors++;
      $display("FAIL rev_count steps=%0d laps=%0d lap_at=%0d exp 12/1/12", nsteps, laps, lap_at);
    end
  endtask

  task automatic test_speed();
    int nsteps = 0;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 6; c++) clk_step();
    spd = 2'd3;
    for (int c = 0; c < 5; c++) begin
      clk_step();
      checks++;
      if (step_o !== 1'b1 || got !== mdl()) begin
        errors++; $display("FAIL speed_x8 c=%0d got=%b exp=%b step_o=1", c, got, mdl());
      end
    end
    spd = 2'd2;
    for (int c = 0; c < 10; c++) begin
      clk_step();
      if (step_o) nsteps++;
      checks++;
      if (got !== mdl()) begin
        errors++; $display("FAIL speed_x4 c=%0d got=%b exp=%b", c, got, mdl());
      end
    end
    checks++;
    if (nsteps != 5) begin
      errors++; $display("FAIL speed_x4_count got=%0d exp=5", nsteps);
    end
  endtask

  task automatic test_manual();
    int nsteps = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      step_in = 1'b1;
      clk_step();
      step_in = 1'b0;
      if (step_o) nsteps++;
      for (int c = 0; c < 4; c++) begin
        clk_step();
        if (step_o) nsteps++;
      end
    end
    checks++;
    if (nsteps != 3 || got[5:2] !== pos_of(3)) begin
      errors++; $display("FAIL manual steps=%0d pos=%b exp 3 pos=%b", nsteps, got[5:2], pos_of(3));
    end
    en = 1'b1;
    nsteps = 0;
    for (int c = 1; c <= 11; c++) begin
      step_in = (c == 3);
      clk_step();
      if (step_o) nsteps++;
      checks++;
      if (got !== mdl()) begin
        errors++; $display("FAIL manual_en c=%0d got=%b exp=%b", c, got, mdl());
      end
    end
    step_in = 1'b0;
    checks++;
    if (nsteps != 1 || got[5:2] !== pos_of(4)) begin
      errors++; $display("FAIL manual_ignored steps=%0d pos=%b exp 1 pos=%b", nsteps, got[5:2], pos_of(4));
    end
  endtask

  task automatic wait_step(input string name, input logic [3:0] exp_pos);
    int c = 0;
    while (!step_o && c < 20) begin
      clk_step();
      c++;
    end
    checks++;
    if (!step_o) begin
      errors++; $display("FAIL %s timeout got=%b exp_pos=%b", name, got, exp_pos);
    end else if (got[5:2] !== exp_pos) begin
      errors++; $display("FAIL %s got=%b exp=%b", name, got[5:2], exp_pos);
    end
  endtask

  task automatic test_dir_toggle();
    do_reset();
    for (int p = 0; p < 5; p++) pulse_step();
    checks++;
    if (got[5:2] !== pos_of(5)) begin
      errors++; $display("FAIL dir_setup got=%b exp=%b", got[5:2], pos_of(5));
    end
    en = 1'b1;
    clk_step(); clk_step();
    dir = 1'b1;
    clk_step();
    wait_step("dir_rev", pos_of(4));
    clk_step();
    dir = 1'b0;
    wait_step("dir_fwd_back", pos_of(5));
    clk_step();
    dir = 1'b1;
    clk_step();
    dir = 1'b0;
    wait_step("dir_fwd_lower", pos_of(6));
  endtask

  task automatic test_reset_mid();
    int first = 0;
    do_reset();
    for (int p = 0; p < 8; p++) pulse_step();
    checks++;
    if (got[5:2] !== pos_of(8)) begin
      errors++; $display("FAIL rst_setup got=%b exp=%b", got[5:2], pos_of(8));
    end
    en = 1'b1;
    clk_step(); clk_step(); clk_step();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got !== 6'b0) begin
      errors++; $display("FAIL rst_mid_count got=%b exp=%b", got, 6'b0);
    end
    en = 1'b0;
    clk_step();
    rst = 1'b0;
    en  = 1'b1;
    for (int c = 1; c <= 20 && first == 0; c++) begin
      clk_step();
      if (step_o) first = c;
    end
    checks++;
    if (first != 8) begin
      errors++; $display("FAIL rst_first_tick got=%0d exp=8", first);
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got !== 6'b0) begin
      errors++; $display("FAIL rst_mid_pulse got=%b exp=%b", got, 6'b0);
    end
    en = 1'b0;
    clk_step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 31) == 0) spd = 2'($urandom_range(0, 3));
      step_in = en ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
      clk_step();
      checks++;
      if (got !== mdl()) begin
        errors++; $display("FAIL random c=%0d got=%b exp=%b", c, got, mdl());
      end
    end
    step_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_speed();
    test_manual();
    test_dir_toggle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
